store_monitor: RTL and testbench

- Synthesizable pass/fail monitor on the data-memory write bus of the single-cycle processor (`top`).
- Sits downstream of the core, alongside data memory, and samples `memwrite`/`dataadr`/`writedata` on the same rising edge that commits the store.
- Reports a sticky pass/fail verdict with a failure code, a store count and a timeout, so self-checking runs on hardware without a simulator.

---
 rtl/store_monitor.sv | 132 +++++++++++++
 tb/tb_store_monitor.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/store_monitor.sv
// rtl/store_monitor.sv - sticky pass/fail monitor on the core's data-memory store bus
//
// Watches every store committed by the single-cycle core and reaches a
// sticky verdict: PASS when the program writes PASS_DATA to PASS_ADDR,
// FAIL on a store anywhere other than PASS_ADDR/ALLOW_ADDR, on wrong data
// at PASS_ADDR, or when TIMEOUT cycles elapse without a verdict.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   clear        synchronous restart into RUN with all counters zeroed
//   memwrite     store strobe from the core
//   dataadr      store address
//   writedata    store data
//   done         verdict reached (pass | fail)
//   pass         program signalled success
//   fail         program failed; reason in fail_code
//   fail_code    0 none, 1 illegal address, 2 wrong data, 3 timeout
//   store_count  stores seen in RUN, saturating
//   cycle_count  cycles spent in RUN, never above TIMEOUT
//   last_addr    address of the latest store seen in RUN
//   last_data    data of the latest store seen in RUN

module store_monitor #(
  parameter int          WIDTH      = 32,
  parameter int unsigned PASS_ADDR  = 84,
  parameter int unsigned PASS_DATA  = 7,
  parameter int unsigned ALLOW_ADDR = 80,
  parameter int unsigned TIMEOUT    = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] dataadr,
  input  logic [WIDTH-1:0] writedata,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       fail_code,
  output logic [15:0]      store_count,
  output logic [15:0]      cycle_count,
  output logic [WIDTH-1:0] last_addr,
  output logic [WIDTH-1:0] last_data
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_PASS = 2'd1,
    S_FAIL = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] PASS_A  = WIDTH'(PASS_ADDR);
  localparam logic [WIDTH-1:0] PASS_D  = WIDTH'(PASS_DATA);
  localparam logic [WIDTH-1:0] ALLOW_A = WIDTH'(ALLOW_ADDR);
  localparam logic [15:0]      TO_LAST = 16'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [1:0]       code_d;
  logic [15:0]      sc_d, cc_d;
  logic [WIDTH-1:0] la_d, ld_d;
  logic             at_pass, at_allow;

  assign at_pass  = (dataadr == PASS_A);
  assign at_allow = (dataadr == ALLOW_A);

  always_comb begin
    state_d = state_q;
    code_d  = fail_code;
    sc_d    = store_count;
    cc_d    = cycle_count;
    la_d    = last_addr;
    ld_d    = last_data;
    if (clear) begin
      // Restart wins over any store on the same edge; that store is dropped.
      state_d = S_RUN;
      code_d  = 2'd0;
      sc_d    = '0;
      cc_d    = '0;
      la_d    = '0;
      ld_d    = '0;
    end else if (state_q == S_RUN) begin
      cc_d = cycle_count + 16'd1;
      if (memwrite) begin
        // The deciding store is recorded too, so last_* shows what ended the run.
        if (store_count != 16'hFFFF) sc_d = store_count + 16'd1;
        la_d = dataadr;
        ld_d = writedata;
      end
      // Decisive stores outrank the timeout; an allowed store does not.
      if (memwrite && at_pass && writedata == PASS_D) begin
        state_d = S_PASS;
      end else if (memwrite && at_pass) begin
        state_d = S_FAIL;
        code_d  = 2'd2;
      end else if (memwrite && !at_allow) begin
        state_d = S_FAIL;
        code_d  = 2'd1;
      end else if (cycle_count == TO_LAST) begin
        state_d = S_FAIL;
        code_d  = 2'd3;
      end
    end
  end

  // Verdict flags are registered from the next state so they share the
  // state register's timing and are never high together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_RUN;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      fail_code   <= 2'd0;
      store_count <= '0;
      cycle_count <= '0;
      last_addr   <= '0;
      last_data   <= '0;
    end else begin
      state_q     <= state_d;
      done        <= (state_d != S_RUN);
      pass        <= (state_d == S_PASS);
      fail        <= (state_d == S_FAIL);
      fail_code   <= code_d;
      store_count <= sc_d;
      cycle_count <= cc_d;
      last_addr   <= la_d;
      last_data   <= ld_d;
    end
  end

endmodule

// File: tb/tb_store_monitor.sv
// tb/tb_store_monitor.sv - directed self-checking bench for store_monitor

module tb_store_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic        done, pass, fail;
  logic [1:0]  fail_code;
  logic [15:0] store_count, cycle_count;
  logic [31:0] last_addr, last_data;

  int total = 0;
  int bad   = 0;

  store_monitor #(
    .WIDTH(32), .PASS_ADDR(84), .PASS_DATA(7), .ALLOW_ADDR(80), .TIMEOUT(20)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear), .memwrite(memwrite),
    .dataadr(dataadr), .writedata(writedata), .done(done), .pass(pass),
    .fail(fail), .fail_code(fail_code), .store_count(store_count),
    .cycle_count(cycle_count), .last_addr(last_addr), .last_data(last_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock edge with the given bus values; returns 1 time unit after it.
  task automatic cyc(input logic mw, input logic [31:0] a, input logic [31:0] d);
    memwrite  = mw;
    dataadr   = a;
    writedata = d;
    @(posedge clk);
    #1;
    memwrite  = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc(1'b0, 32'd0, 32'd0);
    clear = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; clear = 1'b0; memwrite = 1'b0; dataadr = '0; writedata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail", fail, 0);
    chk("rst_code", fail_code, 0);
    chk("rst_sc", store_count, 0);
    chk("rst_cc", cycle_count, 0);
    chk("rst_la", last_addr, 0);
    chk("rst_ld", last_data, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("first_cc", cycle_count, 1);

    // pass scenario
    do_clear();
    cyc(1'b1, 32'd80, 32'd7);
    chk("p1_sc", store_count, 1);
    chk("p1_pass", pass, 0);
    cyc(1'b1, 32'd80, 32'd3);
    cyc(1'b1, 32'd84, 32'd7);
    chk("p_pass", pass, 1);
    chk("p_done", done, 1);
    chk("p_fail", fail, 0);
    chk("p_code", fail_code, 0);
    chk("p_sc", store_count, 3);
    chk("p_la", last_addr, 84);
    chk("p_ld", last_data, 7);
    chk("p_cc", cycle_count, 3);
    cyc(1'b1, 32'd88, 32'd1);
    idle(2);
    chk("p_sticky_pass", pass, 1);
    chk("p_sticky_fail", fail, 0);
    chk("p_frozen_sc", store_count, 3);
    chk("p_frozen_la", last_addr, 84);
    chk("p_frozen_cc", cycle_count, 3);

    // illegal address
    do_clear();
    chk("clr_pass", pass, 0);
    chk("clr_sc", store_count, 0);
    cyc(1'b1, 32'd88, 32'd1);
    chk("ill_fail", fail, 1);
    chk("ill_done", done, 1);
    chk("ill_pass", pass, 0);
    chk("ill_code", fail_code, 1);
    chk("ill_la", last_addr, 88);
    chk("ill_sc", store_count, 1);
    cyc(1'b1, 32'd84, 32'd7);
    chk("ill_sticky", fail_code, 1);

    // clear with concurrent store, then pass on the next edge
    clear = 1'b1;
    cyc(1'b1, 32'd84, 32'd7);
    clear = 1'b0;
    chk("cs_done", done, 0);
    chk("cs_fail", fail, 0);
    chk("cs_pass", pass, 0);
    chk("cs_code", fail_code, 0);
    chk("cs_sc", store_count, 0);
    chk("cs_cc", cycle_count, 0);
    chk("cs_la", last_addr, 0);
    chk("cs_ld", last_data, 0);
    cyc(1'b1, 32'd84, 32'd7);
    chk("cs_next_pass", pass, 1);
    chk("cs_next_sc", store_count, 1);

    // wrong data at PASS_ADDR
    do_clear();
    cyc(1'b1, 32'd84, 32'd6);
    chk("wd_fail", fail, 1);
    chk("wd_code", fail_code, 2);
    chk("wd_ld", last_data, 6);

    // timeout with no stores
    do_clear();
    idle(19);
    chk("to_cc19", cycle_count, 19);
    chk("to_fail19", fail, 0);
    idle(1);
    chk("to_fail", fail, 1);
    chk("to_code", fail_code, 3);
    chk("to_cc", cycle_count, 20);
    idle(3);
    chk("to_cc_frozen", cycle_count, 20);

    // passing store exactly on the timeout edge
    do_clear();
    idle(19);
    cyc(1'b1, 32'd84, 32'd7);
    chk("tp_pass", pass, 1);
    chk("tp_fail", fail, 0);
    chk("tp_code", fail_code, 0);
    chk("tp_sc", store_count, 1);

    // allowed store on the timeout edge: counted, timeout still fires
    do_clear();
    idle(19);
    cyc(1'b1, 32'd80, 32'd5);
    chk("ta_fail", fail, 1);
    chk("ta_code", fail_code, 3);
    chk("ta_sc", store_count, 1);
    chk("ta_la", last_addr, 80);

    // asynchronous reset mid-run
    do_clear();
    cyc(1'b1, 32'd80, 32'd1);
    cyc(1'b1, 32'd80, 32'd2);
    chk("rm_sc_pre", store_count, 2);
    #2;
    reset = 1'b0;
    #1;
    chk("rm_sc", store_count, 0);
    chk("rm_cc", cycle_count, 0);
    chk("rm_la", last_addr, 0);
    chk("rm_ld", last_data, 0);
    @(negedge clk);
    reset = 1'b1;
    cyc(1'b1, 32'd80, 32'd9);
    chk("rm_after_sc", store_count, 1);
    chk("rm_after_cc", cycle_count, 1);
    chk("rm_after_ld", last_data, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
